store_rmw_unit: RTL and testbench

//  Parametrised sequential successor of the combinational store mask.

---
 rtl/store_rmw_unit_if.sv | 28 ++
 rtl/store_rmw_unit.sv | 164 ++++++++++++++++
 tb/tb_store_rmw_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_rmw_unit_if.sv
// Bus between the control unit / data memory side and the store read-modify-write unit.
// The master side issues requests and returns memory read data; the slave side is the unit.
interface store_rmw_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] b;
    logic [1:0]        ct;
    logic [DATA_W-1:0] mr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wd;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, addr, b, ct, mr,
        input  mem_addr, mem_wr, mem_wd, busy, done, err
    );

    modport slave (
        input  start, addr, b, ct, mr,
        output mem_addr, mem_wr, mem_wd, busy, done, err
    );
endinterface

// File: rtl/store_rmw_unit.sv
// Sub-word store engine: reads the target word, merges the byte/half lane from B and
// writes it back; word stores go straight to the write cycle. All outputs are registered.
module store_rmw_unit #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter bit ALLOW_OFFSET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    store_rmw_unit_if.slave  bus
);
    localparam int LANE_W = $clog2(DATA_W / 8);
    localparam int NBYTES = DATA_W / 8;

    localparam logic [1:0] CT_WORD = 2'd0;
    localparam logic [1:0] CT_HALF = 2'd1;
    localparam logic [1:0] CT_RSVD = 2'd3;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]        cnt_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [1:0]        ct_reg;
    logic [DATA_W-1:0] b_reg;

    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wd_reg;
    logic              mem_wr_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    // Request decode; only meaningful while IDLE
    logic [LANE_W-1:0] lane_in;
    logic [ADDR_W-1:0] access_addr;
    logic              req_bad;
    logic              req_seen;
    logic              accept;
    logic              read_last;
    logic [DATA_W-1:0] merged;

    always_comb begin
        lane_in     = '0;
        access_addr = bus.addr;
        if (ALLOW_OFFSET) begin
            lane_in     = bus.addr[LANE_W-1:0];
            access_addr = {bus.addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        end
    end

    assign req_bad   = (bus.ct == CT_RSVD) || ((bus.ct == CT_HALF) && lane_in[0]);
    assign req_seen  = (state_reg == IDLE) && bus.start;
    assign accept    = req_seen && !req_bad;
    assign read_last = (state_reg == READ) && (cnt_reg == LAST_CNT);

    // Each byte lane takes B's low byte at the addressed lane, B's second byte one lane
    // above it for halfword stores, and the fetched memory byte everywhere else.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            localparam logic [LANE_W-1:0] LIDX    = LANE_W'(gi);
            localparam logic [LANE_W-1:0] LIDX_LO = LANE_W'(gi - 1);
            logic sel_lo;
            logic sel_hi;
            assign sel_lo = (lane_reg == LIDX);
            assign sel_hi = (ct_reg == CT_HALF) && (gi > 0) && (lane_reg == LIDX_LO);
            assign merged[8*gi +: 8] = sel_lo ? b_reg[7:0]  :
                                       sel_hi ? b_reg[15:8] :
                                                bus.mr[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (bus.ct == CT_WORD) ? WRITE : READ;
                end
            end
            READ: begin
                if (read_last) begin
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read-latency counter and latched request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= '0;
            lane_reg <= '0;
            ct_reg   <= '0;
            b_reg    <= '0;
        end else begin
            if (accept) begin
                cnt_reg  <= '0;
                lane_reg <= lane_in;
                ct_reg   <= bus.ct;
                b_reg    <= bus.b;
            end else if (state_reg == READ) begin
                cnt_reg <= cnt_reg + 3'd1;
            end
        end
    end

    // Memory-side address/data hold their last values between accesses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_reg <= '0;
            mem_wd_reg   <= '0;
        end else begin
            if (accept) begin
                mem_addr_reg <= access_addr;
                if (bus.ct == CT_WORD) begin
                    mem_wd_reg <= bus.b;
                end
            end else if (read_last) begin
                mem_wd_reg <= merged;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_wr_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            mem_wr_reg <= (state_next == WRITE);
            busy_reg   <= (state_next != IDLE);
            done_reg   <= (state_next == WRITE);
            err_reg    <= req_seen && req_bad;
        end
    end

    assign bus.mem_addr = mem_addr_reg;
    assign bus.mem_wd   = mem_wd_reg;
    assign bus.mem_wr   = mem_wr_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.err      = err_reg;
endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit: three instances cover MEM_LAT=1, MEM_LAT=3 and
// the fixed-lane (ALLOW_OFFSET=0) variant, each fed by a small latency-accurate memory model.
module tb_store_rmw_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   wr_cnt;

    always #5 clk = ~clk;

    store_rmw_unit_if #(.DATA_W(32), .ADDR_W(32)) ia ();
    store_rmw_unit_if #(.DATA_W(32), .ADDR_W(32)) ib ();
    store_rmw_unit_if #(.DATA_W(32), .ADDR_W(32)) ic ();

    store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .ALLOW_OFFSET(1'b1))
        ua (.clk(clk), .reset(reset), .bus(ia));
    store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(3), .ALLOW_OFFSET(1'b1))
        ub (.clk(clk), .reset(reset), .bus(ib));
    store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1), .ALLOW_OFFSET(1'b0))
        uc (.clk(clk), .reset(reset), .bus(ic));

    // Memory model: read data is valid MEM_LAT cycles after the address first appears,
    // and is a poison pattern before that so early capture shows up as a wrong merge.
    logic [31:0] mem_a, mem_b, mem_c;
    logic       va = 1'b0;
    logic [2:0] vb = 3'b000;
    logic       vc = 1'b0;

    always @(posedge clk) begin
        va <= ia.busy & ~ia.mem_wr;
        vb <= {vb[1:0], ib.busy & ~ib.mem_wr};
        vc <= ic.busy & ~ic.mem_wr;
    end

    assign ia.mr = va    ? mem_a : 32'hA5A5A5A5;
    assign ib.mr = vb[2] ? mem_b : 32'hA5A5A5A5;
    assign ic.mr = vc    ? mem_c : 32'hA5A5A5A5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic [1:0] ct, input logic [31:0] addr, input logic [31:0] b);
        ia.start = 1'b1;
        ia.ct    = ct;
        ia.addr  = addr;
        ia.b     = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ia.start = 1'b0; ia.ct = 2'd0; ia.addr = '0; ia.b = '0;
        ib.start = 1'b0; ib.ct = 2'd0; ib.addr = '0; ib.b = '0;
        ic.start = 1'b0; ic.ct = 2'd0; ic.addr = '0; ic.b = '0;
        mem_a = 32'h0; mem_b = 32'h0; mem_c = 32'h0;
        step();
        step();

        // Reset state
        chk("rst_mem_wr", ia.mem_wr, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_err", ia.err, 0);
        chk("rst_mem_addr", ia.mem_addr, 0);
        chk("rst_mem_wd", ia.mem_wd, 0);
        reset = 1'b0;
        step();

        // 1: word store, no read cycle
        mem_a = 32'hFFFFFFFF;
        req_a(2'd0, 32'h100, 32'h00000008);
        step();
        ia.start = 1'b0;
        ia.b = 32'h77777777;
        chk("w_wr_k1", ia.mem_wr, 1);
        chk("w_done_k1", ia.done, 1);
        chk("w_busy_k1", ia.busy, 1);
        chk("w_wd_k1", ia.mem_wd, 32'h00000008);
        chk("w_addr_k1", ia.mem_addr, 32'h100);
        step();
        chk("w_wr_k2", ia.mem_wr, 0);
        chk("w_busy_k2", ia.busy, 0);
        chk("w_wd_hold", ia.mem_wd, 32'h00000008);

        // 2: halfword at lane 2
        req_a(2'd1, 32'h102, 32'h1234ABCD);
        step();
        ia.start = 1'b0;
        chk("h_addr_k1", ia.mem_addr, 32'h100);
        chk("h_wr_k1", ia.mem_wr, 0);
        chk("h_busy_k1", ia.busy, 1);
        step();
        chk("h_wr_k2", ia.mem_wr, 0);
        step();
        chk("h_wr_k3", ia.mem_wr, 1);
        chk("h_done_k3", ia.done, 1);
        chk("h_wd_k3", ia.mem_wd, 32'hABCDFFFF);
        step();
        chk("h_wr_k4", ia.mem_wr, 0);
        chk("h_busy_k4", ia.busy, 0);

        // 3: byte at lane 3
        mem_a = 32'h11223344;
        req_a(2'd2, 32'h103, 32'h00000008);
        step();
        ia.start = 1'b0;
        ia.b = 32'hFFFFFFFF;
        chk("b_wr_k1", ia.mem_wr, 0);
        step();
        chk("b_wr_k2", ia.mem_wr, 0);
        step();
        chk("b_wr_k3", ia.mem_wr, 1);
        chk("b_wd_k3", ia.mem_wd, 32'h08223344);
        chk("b_addr_k3", ia.mem_addr, 32'h100);
        step();

        // 3 with MEM_LAT=3: write at k+5
        mem_b = 32'h11223344;
        ib.start = 1'b1; ib.ct = 2'd2; ib.addr = 32'h103; ib.b = 32'h08;
        step();
        ib.start = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("lat3_no_wr", ib.mem_wr, 0);
            chk("lat3_busy", ib.busy, 1);
            step();
        end
        chk("lat3_wr_k5", ib.mem_wr, 1);
        chk("lat3_wd_k5", ib.mem_wd, 32'h08223344);
        chk("lat3_addr", ib.mem_addr, 32'h100);
        step();
        chk("lat3_wr_k6", ib.mem_wr, 0);

        // 4: misaligned half and reserved size are rejected
        req_a(2'd1, 32'h101, 32'h0000BEEF);
        step();
        ia.start = 1'b0;
        chk("e1_err_k1", ia.err, 1);
        chk("e1_busy_k1", ia.busy, 0);
        chk("e1_wr_k1", ia.mem_wr, 0);
        step();
        chk("e1_err_k2", ia.err, 0);
        chk("e1_busy_k2", ia.busy, 0);
        req_a(2'd3, 32'h204, 32'h0000BEEF);
        step();
        ia.start = 1'b0;
        chk("e3_err_k1", ia.err, 1);
        chk("e3_busy_k1", ia.busy, 0);
        chk("e3_wr_k1", ia.mem_wr, 0);
        chk("e3_addr_hold", ia.mem_addr, 32'h100);
        step();
        chk("e3_err_k2", ia.err, 0);
        chk("e3_wr_k2", ia.mem_wr, 0);

        // 5: START during READ and during WRITE is ignored
        mem_a = 32'h11223344;
        req_a(2'd2, 32'h100, 32'h00000055);
        step();
        req_a(2'd0, 32'h200, 32'h00000000);
        chk("s_busy_k1", ia.busy, 1);
        chk("s_wr_k1", ia.mem_wr, 0);
        step();
        ia.start = 1'b0;
        chk("s_wr_k2", ia.mem_wr, 0);
        chk("s_addr_k2", ia.mem_addr, 32'h100);
        step();
        chk("s_wr_k3", ia.mem_wr, 1);
        chk("s_wd_k3", ia.mem_wd, 32'h11223355);
        chk("s_addr_k3", ia.mem_addr, 32'h100);
        req_a(2'd0, 32'h300, 32'h0000CAFE);
        step();
        ia.start = 1'b0;
        chk("s_wr_k4", ia.mem_wr, 0);
        chk("s_busy_k4", ia.busy, 0);
        step();
        chk("s_wr_k5", ia.mem_wr, 0);
        chk("s_wd_k5", ia.mem_wd, 32'h11223355);

        // 5: reset mid-READ drops outputs at once and cancels the write
        req_a(2'd2, 32'h104, 32'h00000099);
        step();
        ia.start = 1'b0;
        chk("r_busy_pre", ia.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_busy_async", ia.busy, 0);
        chk("r_wr_async", ia.mem_wr, 0);
        step();
        reset = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ia.mem_wr) wr_cnt++;
        end
        chk("r_no_write", wr_cnt, 0);

        // Fresh store after reset release
        mem_a = 32'h01020304;
        req_a(2'd1, 32'h106, 32'h0000BEEF);
        step();
        ia.start = 1'b0;
        chk("f_addr_k1", ia.mem_addr, 32'h104);
        step();
        step();
        chk("f_wr_k3", ia.mem_wr, 1);
        chk("f_wd_k3", ia.mem_wd, 32'hBEEF0304);
        step();

        // 6: fixed lane, unaligned address passed through
        mem_c = 32'hFFFFFFFF;
        ic.start = 1'b1; ic.ct = 2'd2; ic.addr = 32'h103; ic.b = 32'h8;
        step();
        ic.start = 1'b0;
        chk("o_addr_k1", ic.mem_addr, 32'h103);
        chk("o_wr_k1", ic.mem_wr, 0);
        step();
        step();
        chk("o_wr_k3", ic.mem_wr, 1);
        chk("o_wd_k3", ic.mem_wd, 32'hFFFFFF08);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
